// File: rtl/hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg -- shared types and constants for the pipeline hazard unit.
//   fwd_sel_t : operand source select (register file / EX result / MEM result)
//   state_t   : hazard-unit FSM states (RUN, FLUSH)
//   ZERO_REG_DEFAULT : register index hard-wired to zero (XZR), never matches
//   sat_inc() : 16-bit saturating increment used by the performance counters
// ---------------------------------------------------------------------------
package hazard_pkg;

  localparam int ZERO_REG_DEFAULT = 31;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EX  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == CNT_MAX) ? v : v + 16'd1;
  endfunction

  // A value still sitting in EX as a load has not been read from memory yet,
  // so it cannot be forwarded; MEM is the fallback source.
  function automatic fwd_sel_t fwd_pick(input logic m_ex, input logic ex_load,
                                        input logic m_mem);
    if (m_ex && !ex_load) return FWD_EX;
    if (m_mem)            return FWD_MEM;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_if -- bundle between the pipeline datapath and the hazard unit.
//   master : pipeline side; drives decode/EX/MEM status, reads the controls
//   slave  : hazard unit; reads status, drives pipeline-register controls,
//            forwarding selects and performance counters
// ---------------------------------------------------------------------------
interface hazard_ctrl_if #(
  parameter int REG_W = 5
);
  import hazard_pkg::*;

  // Decode-stage sources
  logic [REG_W-1:0] id_rn;
  logic [REG_W-1:0] id_rm;
  logic             id_rn_used;
  logic             id_rm_used;
  // EX-stage destination
  logic [REG_W-1:0] ex_rd;
  logic             ex_regwrite;
  logic             ex_memread;
  // MEM-stage destination
  logic [REG_W-1:0] mem_rd;
  logic             mem_regwrite;
  // Branch / memory status
  logic             br_taken;
  logic             mem_wait;
  // Pipeline controls
  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_bubble;
  fwd_sel_t         fwd_a;
  fwd_sel_t         fwd_b;
  logic [15:0]      stall_count;
  logic [15:0]      flush_count;

  modport master (
    output id_rn, id_rm, id_rn_used, id_rm_used,
           ex_rd, ex_regwrite, ex_memread,
           mem_rd, mem_regwrite, br_taken, mem_wait,
    input  pc_en, ifid_en, ifid_flush, idex_bubble,
           fwd_a, fwd_b, stall_count, flush_count
  );

  modport slave (
    input  id_rn, id_rm, id_rn_used, id_rm_used,
           ex_rd, ex_regwrite, ex_memread,
           mem_rd, mem_regwrite, br_taken, mem_wait,
    output pc_en, ifid_en, ifid_flush, idex_bubble,
           fwd_a, fwd_b, stall_count, flush_count
  );

endinterface

// File: rtl/hazard_ctrl_reg_match.sv
// ---------------------------------------------------------------------------
// reg_match -- register-index dependency comparator.
//   src_i, src_used_i : consumer source index and its valid flag
//   dst_i, dst_we_i   : producer destination index and its write flag
//   match_o           : 1 when a live source reads a written destination that
//                       is not the zero register
// ---------------------------------------------------------------------------
module reg_match #(
  parameter int REG_W    = 5,
  parameter int ZERO_REG = 31
) (
  input  logic [REG_W-1:0] src_i,
  input  logic             src_used_i,
  input  logic [REG_W-1:0] dst_i,
  input  logic             dst_we_i,
  output logic             match_o
);

  localparam logic [REG_W-1:0] ZERO_IDX = REG_W'(ZERO_REG);

  assign match_o = src_used_i && dst_we_i && (src_i == dst_i) && (src_i != ZERO_IDX);

endmodule

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl -- in-order pipeline hazard unit: operand forwarding, load-use
// stall, taken-branch fetch squash, memory-wait freeze.
//   clk   : rising-edge clock
//   reset : synchronous, active-high; forces RUN, clears counters
//   hz    : hazard_ctrl_if.slave (status in, pipeline controls out)
// Parameters: REG_W (index width), ZERO_REG (never-matching index),
//   FLUSH_CYCLES (1..7 fetch slots squashed per taken branch).
// Optional feature: define HAZARD_CTRL_PERF_CNT_EN to build the saturating
// stall/flush performance counters; otherwise both counters read 0.
// ---------------------------------------------------------------------------
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_W        = 5,
  parameter int ZERO_REG     = ZERO_REG_DEFAULT,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave hz
);

  // Remaining squash slots after the branch cycle itself.
  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;

  logic match_ex_rn, match_ex_rm, match_mem_rn, match_mem_rm;
  logic load_use;

  reg_match #(.REG_W(REG_W), .ZERO_REG(ZERO_REG)) u_match_ex_rn (
    .src_i(hz.id_rn), .src_used_i(hz.id_rn_used),
    .dst_i(hz.ex_rd), .dst_we_i(hz.ex_regwrite), .match_o(match_ex_rn)
  );
  reg_match #(.REG_W(REG_W), .ZERO_REG(ZERO_REG)) u_match_ex_rm (
    .src_i(hz.id_rm), .src_used_i(hz.id_rm_used),
    .dst_i(hz.ex_rd), .dst_we_i(hz.ex_regwrite), .match_o(match_ex_rm)
  );
  reg_match #(.REG_W(REG_W), .ZERO_REG(ZERO_REG)) u_match_mem_rn (
    .src_i(hz.id_rn), .src_used_i(hz.id_rn_used),
    .dst_i(hz.mem_rd), .dst_we_i(hz.mem_regwrite), .match_o(match_mem_rn)
  );
  reg_match #(.REG_W(REG_W), .ZERO_REG(ZERO_REG)) u_match_mem_rm (
    .src_i(hz.id_rm), .src_used_i(hz.id_rm_used),
    .dst_i(hz.mem_rd), .dst_we_i(hz.mem_regwrite), .match_o(match_mem_rm)
  );

  assign load_use = hz.ex_memread && (match_ex_rn || match_ex_rm);

  // Forwarding is independent of FSM state; only reset masks it.
  assign hz.fwd_a = reset ? FWD_RF : fwd_pick(match_ex_rn, hz.ex_memread, match_mem_rn);
  assign hz.fwd_b = reset ? FWD_RF : fwd_pick(match_ex_rm, hz.ex_memread, match_mem_rm);

  // NOTE: every output and next-state variable gets a default before any
  // branch, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    hz.pc_en       = 1'b1;
    hz.ifid_en     = 1'b1;
    hz.ifid_flush  = 1'b0;
    hz.idex_bubble = 1'b0;

    if (reset) begin
      // Hold fetch and inject bubbles while the pipeline is being reset.
      hz.pc_en       = 1'b0;
      hz.ifid_en     = 1'b0;
      hz.ifid_flush  = 1'b1;
      hz.idex_bubble = 1'b1;
    end else if (hz.mem_wait) begin
      // Full freeze: nothing advances, nothing is squashed, FSM holds.
      hz.pc_en   = 1'b0;
      hz.ifid_en = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (hz.br_taken) begin
            // Branch wins over a concurrent load-use: the dependent
            // instruction is on the wrong path and gets squashed anyway.
            hz.ifid_flush  = 1'b1;
            hz.idex_bubble = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_d = FLUSH;
              cnt_d   = FLUSH_INIT;
            end
          end else if (load_use) begin
            hz.pc_en       = 1'b0;
            hz.ifid_en     = 1'b0;
            hz.idex_bubble = 1'b1;
          end
        end
        FLUSH: begin
          hz.ifid_flush  = 1'b1;
          hz.idex_bubble = 1'b1;
          cnt_d          = cnt_q - 3'd1;
          if (cnt_q <= 3'd1) begin
            state_d = RUN;
            cnt_d   = 3'd0;
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = 3'd0;
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge value of its neighbours regardless of process order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_CTRL_PERF_CNT_EN
  logic [15:0] stall_cnt_q, flush_cnt_q;
  logic        stall_evt;

  // A counted stall is exactly the RUN load-use cycle that drives pc_en low.
  assign stall_evt = !reset && !hz.mem_wait && (state_q == RUN) && !hz.br_taken && load_use;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      if (stall_evt)     stall_cnt_q <= sat_inc(stall_cnt_q);
      // ifid_flush is already 0 under mem_wait, so the counter holds then.
      if (hz.ifid_flush) flush_cnt_q <= sat_inc(flush_cnt_q);
    end
  end

  assign hz.stall_count = stall_cnt_q;
  assign hz.flush_count = flush_cnt_q;
`else
  assign hz.stall_count = 16'd0;
  assign hz.flush_count = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl -- directed self-checking bench for hazard_ctrl.
// dut  : FLUSH_CYCLES=3 (multi-cycle squash, mem_wait freeze, reset abort)
// dut1 : FLUSH_CYCLES=1 (branch squashes a single slot and stays in RUN)
// Counter expectations follow HAZARD_CTRL_PERF_CNT_EN.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;
  import hazard_pkg::*;

`ifdef HAZARD_CTRL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_W(5)) bus ();
  hazard_ctrl_if #(.REG_W(5)) bus1 ();

  hazard_ctrl #(.REG_W(5), .ZERO_REG(31), .FLUSH_CYCLES(3)) dut (
    .clk(clk), .reset(reset), .hz(bus.slave)
  );
  hazard_ctrl #(.REG_W(5), .ZERO_REG(31), .FLUSH_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .hz(bus1.slave)
  );

  // {pc_en, ifid_en, ifid_flush, idex_bubble}
  logic [3:0] ctl, ctl1;
  assign ctl  = {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_bubble};
  assign ctl1 = {bus1.pc_en, bus1.ifid_en, bus1.ifid_flush, bus1.idex_bubble};

  int n_checks = 0;
  int n_fail   = 0;
  int exp_stall = 0;  // stall cycles the counter should have seen (dut)
  int exp_flush = 0;  // flush cycles the counter should have seen (dut)

  function automatic logic [15:0] exp_cnt(input int n);
    if (!PERF) return 16'd0;
    return (n > 65535) ? 16'hFFFF : 16'(n);
  endfunction

  task automatic idle();
    bus.id_rn = '0;  bus.id_rm = '0;  bus.id_rn_used = 0;  bus.id_rm_used = 0;
    bus.ex_rd = '0;  bus.ex_regwrite = 0;  bus.ex_memread = 0;
    bus.mem_rd = '0; bus.mem_regwrite = 0; bus.br_taken = 0; bus.mem_wait = 0;
    bus1.id_rn = '0;  bus1.id_rm = '0;  bus1.id_rn_used = 0;  bus1.id_rm_used = 0;
    bus1.ex_rd = '0;  bus1.ex_regwrite = 0;  bus1.ex_memread = 0;
    bus1.mem_rd = '0; bus1.mem_regwrite = 0; bus1.br_taken = 0; bus1.mem_wait = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load in EX writing rd=5, decode source rn=5 consumes it.
  task automatic set_load_use();
    bus.id_rn = 5'd5; bus.id_rn_used = 1;
    bus.ex_rd = 5'd5; bus.ex_regwrite = 1; bus.ex_memread = 1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    bus.mem_wait = 1;
    bus.id_rn = 5'd3; bus.id_rn_used = 1; bus.ex_rd = 5'd3; bus.ex_regwrite = 1;
    #2;
    n_checks++;
    if (ctl !== 4'b0011) begin n_fail++; $display("FAIL reset_ctl: got %b expected 0011", ctl); end
    n_checks++;
    if (bus.fwd_a !== FWD_RF) begin n_fail++; $display("FAIL reset_fwd_a: got %b expected 00", bus.fwd_a); end
    tick();
    n_checks++;
    if (bus.stall_count !== 16'd0 || bus.flush_count !== 16'd0) begin
      n_fail++; $display("FAIL reset_counters: got %h/%h expected 0000/0000", bus.stall_count, bus.flush_count);
    end
    reset = 1'b0;
    idle();
    #1;
    n_checks++;
    if (ctl !== 4'b1100) begin n_fail++; $display("FAIL post_reset_ctl: got %b expected 1100", ctl); end
  endtask

  task automatic test_forwarding();
    bus.id_rn = 5'd3; bus.id_rn_used = 1;
    bus.ex_rd = 5'd3; bus.ex_regwrite = 1; bus.ex_memread = 0;
    bus.mem_rd = 5'd3; bus.mem_regwrite = 1;
    #1;
    n_checks++;
    if (bus.fwd_a !== FWD_EX) begin n_fail++; $display("FAIL fwd_ex_priority: got %b expected 01", bus.fwd_a); end
    bus.ex_regwrite = 0;
    #1;
    n_checks++;
    if (bus.fwd_a !== FWD_MEM) begin n_fail++; $display("FAIL fwd_mem: got %b expected 10", bus.fwd_a); end
    bus.id_rn_used = 0;
    #1;
    n_checks++;
    if (bus.fwd_a !== FWD_RF) begin n_fail++; $display("FAIL fwd_unused_src: got %b expected 00", bus.fwd_a); end
    idle();
    bus.id_rm = 5'd31; bus.id_rm_used = 1; bus.ex_rd = 5'd31; bus.ex_regwrite = 1;
    bus.mem_rd = 5'd31; bus.mem_regwrite = 1;
    #1;
    n_checks++;
    if (bus.fwd_b !== FWD_RF || ctl !== 4'b1100) begin
      n_fail++; $display("FAIL zero_reg: got fwd_b=%b ctl=%b expected 00/1100", bus.fwd_b, ctl);
    end
    bus.id_rm = 5'd7; bus.ex_rd = 5'd7; bus.ex_memread = 1; bus.mem_rd = 5'd7;
    #1;
    n_checks++;
    if (bus.fwd_b !== FWD_MEM || ctl !== 4'b0001) begin
      n_fail++; $display("FAIL load_in_ex_fwd: got fwd_b=%b ctl=%b expected 10/0001", bus.fwd_b, ctl);
    end
    idle();
    tick();
  endtask

  task automatic test_load_use();
    bus.id_rm = 5'd5; bus.id_rm_used = 1;
    bus.ex_rd = 5'd5; bus.ex_regwrite = 1; bus.ex_memread = 1;
    #1;
    n_checks++;
    if (ctl !== 4'b0001 || bus.fwd_b !== FWD_RF) begin
      n_fail++; $display("FAIL load_use_stall: got ctl=%b fwd_b=%b expected 0001/00", ctl, bus.fwd_b);
    end
    tick(); exp_stall++;
    bus.ex_rd = 5'd0; bus.ex_regwrite = 0; bus.ex_memread = 0;
    bus.mem_rd = 5'd5; bus.mem_regwrite = 1;
    #1;
    n_checks++;
    if (ctl !== 4'b1100 || bus.fwd_b !== FWD_MEM) begin
      n_fail++; $display("FAIL load_in_mem: got ctl=%b fwd_b=%b expected 1100/10", ctl, bus.fwd_b);
    end
    idle();
    tick();
    n_checks++;
    if (bus.stall_count !== exp_cnt(exp_stall)) begin
      n_fail++; $display("FAIL stall_count_one: got %h expected %h", bus.stall_count, exp_cnt(exp_stall));
    end
  endtask

  task automatic test_branch_flush();
    set_load_use();
    bus.br_taken = 1;
    bus1.br_taken = 1;
    #1;
    n_checks++;
    if (ctl !== 4'b1111 || ctl1 !== 4'b1111) begin
      n_fail++; $display("FAIL branch_over_load_use: got %b/%b expected 1111/1111", ctl, ctl1);
    end
    for (int i = 1; i < 3; i++) begin
      tick(); exp_flush++;
      bus1.br_taken = 0;
      #1;
      n_checks++;
      if (ctl !== 4'b1111) begin n_fail++; $display("FAIL flush_slot_%0d: got %b expected 1111", i, ctl); end
    end
    n_checks++;
    if (ctl1 !== 4'b1100) begin n_fail++; $display("FAIL single_flush_run: got %b expected 1100", ctl1); end
    tick(); exp_flush++;
    bus.br_taken = 0;
    #1;
    n_checks++;
    if (ctl !== 4'b0001) begin n_fail++; $display("FAIL flush_return_run: got %b expected 0001", ctl); end
    idle();
    tick();
    n_checks++;
    if (bus.flush_count !== exp_cnt(exp_flush) || bus.stall_count !== exp_cnt(exp_stall)) begin
      n_fail++; $display("FAIL counts_after_flush: got %h/%h expected %h/%h", bus.stall_count,
                         bus.flush_count, exp_cnt(exp_stall), exp_cnt(exp_flush));
    end
  endtask

  task automatic test_mem_wait();
    bus.br_taken = 1;
    #1;
    tick(); exp_flush++;
    bus.br_taken = 0;
    tick(); exp_flush++;
    bus.mem_wait = 1; bus.br_taken = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if (ctl !== 4'b0000) begin n_fail++; $display("FAIL mem_wait_freeze_%0d: got %b expected 0000", i, ctl); end
      tick();
    end
    bus.mem_wait = 0; bus.br_taken = 0;
    #1;
    n_checks++;
    if (ctl !== 4'b1111) begin n_fail++; $display("FAIL flush_resume: got %b expected 1111", ctl); end
    tick(); exp_flush++;
    n_checks++;
    if (ctl !== 4'b1100 || bus.flush_count !== exp_cnt(exp_flush)) begin
      n_fail++; $display("FAIL flush_done: got ctl=%b cnt=%h expected 1100/%h", ctl, bus.flush_count, exp_cnt(exp_flush));
    end
    set_load_use();
    bus.mem_wait = 1;
    #1;
    n_checks++;
    if (ctl !== 4'b0000) begin n_fail++; $display("FAIL mem_wait_over_stall: got %b expected 0000", ctl); end
    tick();
    n_checks++;
    if (bus.stall_count !== exp_cnt(exp_stall)) begin
      n_fail++; $display("FAIL stall_hold_mem_wait: got %h expected %h", bus.stall_count, exp_cnt(exp_stall));
    end
    idle();
    bus.br_taken = 1;
    tick();
    bus.br_taken = 0;
    reset = 1'b1;
    #1;
    n_checks++;
    if (ctl !== 4'b0011) begin n_fail++; $display("FAIL reset_mid_flush_ctl: got %b expected 0011", ctl); end
    tick();
    reset = 1'b0;
    exp_flush = 0; exp_stall = 0;
    #1;
    n_checks++;
    if (ctl !== 4'b1100) begin n_fail++; $display("FAIL reset_abandons_flush: got %b expected 1100", ctl); end
    n_checks++;
    if (bus.stall_count !== 16'd0 || bus.flush_count !== 16'd0) begin
      n_fail++; $display("FAIL reset_mid_flush_counters: got %h/%h expected 0000/0000", bus.stall_count, bus.flush_count);
    end
  endtask

  task automatic test_saturation();
    set_load_use();
    for (int i = 0; i < 65540; i++) begin
      tick();
      exp_stall++;
    end
    idle();
    #1;
    n_checks++;
    if (bus.stall_count !== exp_cnt(exp_stall)) begin
      n_fail++; $display("FAIL stall_saturate: got %h expected %h", bus.stall_count, exp_cnt(exp_stall));
    end
    n_checks++;
    if (bus.flush_count !== exp_cnt(exp_flush)) begin
      n_fail++; $display("FAIL flush_untouched: got %h expected %h", bus.flush_count, exp_cnt(exp_flush));
    end
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch_flush();
    test_mem_wait();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter REG_W, default 5: register-index width.
REQ-002 Parameter ZERO_REG, default 31: index that never matches (XZR).
REQ-003 Parameter FLUSH_CYCLES, default 1, range 1..7: fetch slots squashed per taken branch.
REQ-004 clk  in  1  rising-edge clock; only clock.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 id_rn, id_rm  in  REG_W  decode-stage source indices; id_rn_used, id_rm_used  in  1  source valid.
REQ-007 ex_rd  in  REG_W; ex_regwrite, ex_memread  in  1  EX-stage destination, write, and load flags.
REQ-008 mem_rd  in  REG_W; mem_regwrite  in  1  MEM-stage destination and write flag.
REQ-009 br_taken  in  1  taken branch resolved in EX; mem_wait  in  1  data memory busy.
REQ-010 pc_en, ifid_en, ifid_flush, idex_bubble  out  1  pipeline-register controls.
REQ-011 fwd_a, fwd_b  out  2  operand source: 00 regfile, 01 EX result, 10 MEM result.
REQ-012 stall_count, flush_count  out  16  performance counters.

Function
REQ-013 match_X_s SHALL be 1 when: s_used, X_regwrite, X_rd==s, and s!=ZERO_REG (X in EX/MEM, s in rn/rm).
REQ-014 fwd_s SHALL be 01 if match_ex_s and !ex_memread; else 10 if match_mem_s; else 00. Combinational, all states, EX over MEM.
REQ-015 load_use SHALL be ex_memread & (match_ex_rn | match_ex_rm).
REQ-016 FSM states SHALL be RUN and FLUSH; a 3-bit counter cnt is used in FLUSH.
REQ-017 mem_wait=1 (any state): pc_en=ifid_en=0, ifid_flush=idex_bubble=0; state, cnt, counters hold; overrides all else.
REQ-018 RUN, br_taken=1: pc_en=1, ifid_en=1, ifid_flush=1, idex_bubble=1; next FLUSH with cnt=FLUSH_CYCLES-1 if FLUSH_CYCLES>1, else stay RUN.
REQ-019 RUN, !br_taken, load_use: pc_en=0, ifid_en=0, ifid_flush=0, idex_bubble=1; stay RUN; one cycle per occurrence.
REQ-020 RUN, neither: pc_en=ifid_en=1, ifid_flush=idex_bubble=0.
REQ-021 FLUSH: pc_en=ifid_en=1, ifid_flush=1, idex_bubble=1; br_taken and load_use ignored; cnt decrements; return to RUN in the cycle after cnt==1 decrements to 0.
REQ-022 Branch and load_use in the same RUN cycle: branch wins, no stall.
REQ-023 Control outputs SHALL be combinational from state and inputs; zero latency.

Reset
REQ-024 reset=1 at a clock edge: state=RUN, cnt=0, counters=0; overrides mem_wait and everything else.
REQ-025 While reset=1: pc_en=ifid_en=0, ifid_flush=idex_bubble=1, fwd_a=fwd_b=00.
REQ-026 Reset asserted mid-FLUSH abandons the remaining flush; the first cycle after reset is RUN.

Configuration
REQ-027 Macro HAZARD_CTRL_PERF_CNT_EN defined: stall_count increments on each REQ-019 cycle; flush_count increments on each cycle with ifid_flush=1 outside reset; both saturate at 16'hFFFF; both hold during mem_wait.
REQ-028 Macro undefined: counter registers absent; stall_count and flush_count driven constant 0.

Structure
REQ-029 Package hazard_pkg SHALL hold: fwd_sel_t (FWD_RF=00, FWD_EX=01, FWD_MEM=10), state_t (RUN, FLUSH), ZERO_REG default.
REQ-030 Sub-module reg_match SHALL be one parameterized REG_W index-equality comparator with enable and zero-register qualify, instantiated four times.

Verification
REQ-031 id_rn=3 used, ex_rd=3 ex_regwrite=1 ex_memread=0, mem_rd=3 mem_regwrite=1 -> fwd_a=01. Then ex_regwrite=0 -> fwd_a=10.
REQ-032 id_rm=31 used, ex_rd=31 ex_regwrite=1 -> fwd_b=00, no stall.
REQ-033 Load with ex_rd=5 and id_rm=5 used -> one cycle pc_en=0 and idex_bubble=1. Next cycle with the load in MEM -> fwd_b=10, pc_en=1. Counter +1 when enabled.
REQ-034 FLUSH_CYCLES=3, br_taken in RUN with concurrent load_use -> ifid_flush=1 for 3 consecutive cycles, no stall, then RUN; br_taken during FLUSH ignored.
REQ-035 mem_wait=1 for 4 cycles mid-FLUSH -> enables 0, cnt frozen, then flush resumes. reset mid-FLUSH -> RUN next cycle, counters 0.
REQ-036 With the macro, force 65536 stall cycles -> stall_count stays 16'hFFFF. Without the macro -> counts remain 0.
